// File: rtl/pseudo_linear_learner.sv
// Multi-cycle pseudo-linear Boolean learner: chunked popcount, threshold compare and reverse-derivative training.
// Optional PL_PARAM_LOAD_EN adds load_en/load_data for direct parameter loading while idle.
module pseudo_linear_learner #(
  parameter int N_IN  = 784,
  parameter int CHUNK = 16,
  parameter int THR_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  in_data,
  input  logic             in_label,
  input  logic             train_en,
  input  logic [THR_W-1:0] threshold,
`ifdef PL_PARAM_LOAD_EN
  input  logic             load_en,
  input  logic [N_IN-1:0]  load_data,
`endif
  output logic             out_valid,
  output logic             out_pred,
  output logic             out_err,
  output logic [15:0]      err_cnt,
  output logic [N_IN-1:0]  param_out
);
  localparam int NCH = N_IN / CHUNK;
  localparam int CW  = $clog2(N_IN + 1);
  localparam int CIW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CIW-1:0] LAST = CIW'(NCH - 1);

  typedef enum logic [1:0] {IDLE, COUNT, DECIDE, UPDATE} state_t;

  state_t           state;
  logic [N_IN-1:0]  p, x;
  logic             label, train;
  logic [THR_W-1:0] thr;
  logic [CW-1:0]    num, num_p;
  logic [CIW-1:0]   idx;

  logic [CHUNK-1:0] p_chunk, x_chunk, upd_chunk;
  logic [CW-1:0]    cnt_px, cnt_p, num_next, num_p_next;
  logic             pred_next;

  function automatic logic fwd(input logic [CW-1:0] a, input logic [CW-1:0] b,
                               input logic [THR_W-1:0] sh);
    logic [CW-1:0] s;
    s = (int'(sh) >= CW) ? '0 : (b >> sh);
    return (s >= a) ? 1'b0 : 1'b1;
  endfunction

  always_comb begin
    p_chunk    = p[idx*CHUNK +: CHUNK];
    x_chunk    = x[idx*CHUNK +: CHUNK];
    cnt_px     = '0;
    cnt_p      = '0;
    upd_chunk  = p_chunk;
    for (int unsigned m = 0; m < CHUNK; m++) begin
      cnt_px = cnt_px + CW'(p_chunk[m] & x_chunk[m]);
      cnt_p  = cnt_p + CW'(p_chunk[m]);
      // num/num_p/out_pred are frozen at DECIDE values, so each bit sees the full-vector counts
      upd_chunk[m] = p_chunk[m] ^ (fwd(x_chunk[m] ? (p_chunk[m] ? num - CW'(1) : num + CW'(1)) : num,
                                       p_chunk[m] ? num_p - CW'(1) : num_p + CW'(1), thr) != out_pred);
    end
    num_next   = num + cnt_px;
    num_p_next = num_p + cnt_p;
    pred_next  = fwd(num_next, num_p_next, thr);
  end

`ifdef PL_PARAM_LOAD_EN
  assign in_ready = (state == IDLE) && !load_en;
`else
  assign in_ready = (state == IDLE);
`endif
  assign param_out = p;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      p         <= '0;
      x         <= '0;
      label     <= 1'b0;
      train     <= 1'b0;
      thr       <= '0;
      num       <= '0;
      num_p     <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
      out_pred  <= 1'b0;
      out_err   <= 1'b0;
      err_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          out_valid <= 1'b0;
`ifdef PL_PARAM_LOAD_EN
          if (load_en) begin
            p <= load_data;
          end else if (in_valid) begin
`else
          if (in_valid) begin
`endif
            x     <= in_data;
            label <= in_label;
            train <= train_en;
            thr   <= threshold;
            num   <= '0;
            num_p <= '0;
            idx   <= '0;
            state <= COUNT;
          end
        end
        COUNT: begin
          num   <= num_next;
          num_p <= num_p_next;
          // Decision is registered off the final chunk so out_valid lines up with the DECIDE cycle
          if (idx == LAST) begin
            idx       <= '0;
            out_valid <= 1'b1;
            out_pred  <= pred_next;
            out_err   <= pred_next ^ label;
            state     <= DECIDE;
          end else begin
            idx <= idx + CIW'(1);
          end
        end
        DECIDE: begin
          out_valid <= 1'b0;
          if (train && out_err) begin
            if (err_cnt != '1) err_cnt <= err_cnt + 16'd1;
            state <= UPDATE;
          end else begin
            state <= IDLE;
          end
        end
        UPDATE: begin
          p[idx*CHUNK +: CHUNK] <= upd_chunk;
          if (idx == LAST) begin
            idx   <= '0;
            state <= IDLE;
          end else begin
            idx <= idx + CIW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
